neuron_seq: RTL and testbench

NEURON_SEQ -- requirements
Module: neuron_seq

---
 rtl/nn_pkg.sv | 38 +++
 rtl/neuron_mac.sv | 39 +++
 rtl/neuron_seq.sv | 157 +++++++++++++++
 tb/tb_neuron_seq.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared types for the sequential neuron: FSM states, activation-mode
// encodings and the output saturation helper.
package nn_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    ACT  = 2'd2
  } state_t;

  localparam logic ACT_RELU   = 1'b0;
  localparam logic ACT_LINEAR = 1'b1;

  // Clamp a sign-extended accumulator into an out_w-bit result. ReLU clamps to
  // [0, 2^out_w-1]; linear clamps to the signed out_w-bit range. The caller
  // keeps the low out_w bits.
  function automatic logic [63:0] saturate(input logic signed [63:0] acc,
                                           input int unsigned out_w,
                                           input logic mode);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    if (mode == ACT_RELU) begin
      hi = (64'sd1 <<< out_w) - 64'sd1;
      lo = 64'sd0;
    end else begin
      hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (out_w - 1));
    end
    if (acc < lo) begin
      return lo;
    end else if (acc > hi) begin
      return hi;
    end else begin
      return acc;
    end
  endfunction

endpackage

// File: rtl/neuron_mac.sv
// Registered signed multiply-accumulate: unsigned operand a times signed
// weight b, with a synchronous load of an initial value (zero or bias).
module neuron_mac #(
  parameter int DATA_W   = 8,
  parameter int WEIGHT_W = 8,
  parameter int ACC_W    = 24
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       load,
  input  logic signed [ACC_W-1:0]    load_val,
  input  logic                       en,
  input  logic [DATA_W-1:0]          a,
  input  logic signed [WEIGHT_W-1:0] b,
  output logic signed [ACC_W-1:0]    acc
);

  localparam int PROD_W = DATA_W + WEIGHT_W + 1;

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  acc_reg;

  // A zero guard bit keeps the data operand non-negative in the signed product.
  assign prod     = $signed({1'b0, a}) * b;
  assign prod_ext = ACC_W'(prod);
  assign acc      = acc_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_reg <= '0;
    end else if (load) begin
      acc_reg <= load_val;
    end else if (en) begin
      acc_reg <= acc_reg + prod_ext;
    end
  end

endmodule

// File: rtl/neuron_seq.sv
// Sequential single neuron: one product per cycle, then ReLU or linear
// saturation. Define NEURON_BIAS_EN to add a bias port preloading the acc.
module neuron_seq
  import nn_pkg::*;
#(
  parameter int N_INPUTS = 9,
  parameter int DATA_W   = 8,
  parameter int WEIGHT_W = 8,
  parameter int ACC_W    = 24,
  parameter int OUT_W    = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          act_mode,
  input  logic [N_INPUTS*DATA_W-1:0]    inputs,
  input  logic [N_INPUTS*WEIGHT_W-1:0]  weights,
`ifdef NEURON_BIAS_EN
  input  logic signed [ACC_W-1:0]       bias,
`endif
  output logic                          busy,
  output logic [OUT_W-1:0]              out,
  output logic                          done
);

  localparam int IDX_W     = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
  localparam int MIN_ACC_W = DATA_W + WEIGHT_W + $clog2(N_INPUTS) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_INPUTS - 1);

  generate
    if (N_INPUTS < 1 || N_INPUTS > 64) begin : g_bad_n
      $error("neuron_seq: N_INPUTS must be in 1..64");
    end
    if (ACC_W < MIN_ACC_W) begin : g_bad_acc
      $error("neuron_seq: ACC_W too narrow for worst-case sum");
    end
    if (ACC_W > 64 || OUT_W > 63) begin : g_bad_wide
      $error("neuron_seq: ACC_W/OUT_W exceed saturation helper width");
    end
  endgenerate

  state_t                         state_reg, state_next;
  logic [N_INPUTS*DATA_W-1:0]     inputs_reg;
  logic [N_INPUTS*WEIGHT_W-1:0]   weights_reg;
  logic                           mode_reg;
  logic [IDX_W-1:0]               idx_reg, idx_next;
  logic [OUT_W-1:0]               out_reg, out_next;
  logic                           done_reg, done_next;
  logic                           capture;
  logic                           mac_load;
  logic                           mac_en;
  logic signed [ACC_W-1:0]        acc;
  logic signed [ACC_W-1:0]        load_val;
  logic [63:0]                    sat_val;

  logic [DATA_W-1:0]              in_arr [N_INPUTS];
  logic signed [WEIGHT_W-1:0]     w_arr  [N_INPUTS];

  generate
    for (genvar gi = 0; gi < N_INPUTS; gi++) begin : g_unpack
      assign in_arr[gi] = inputs_reg[gi*DATA_W +: DATA_W];
      assign w_arr[gi]  = weights_reg[gi*WEIGHT_W +: WEIGHT_W];
    end
  endgenerate

`ifdef NEURON_BIAS_EN
  assign load_val = bias;
`else
  assign load_val = '0;
`endif

  neuron_mac #(
    .DATA_W   (DATA_W),
    .WEIGHT_W (WEIGHT_W),
    .ACC_W    (ACC_W)
  ) u_mac (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (mac_load),
    .load_val (load_val),
    .en       (mac_en),
    .a        (in_arr[idx_reg]),
    .b        (w_arr[idx_reg]),
    .acc      (acc)
  );

  assign sat_val = saturate(64'(acc), OUT_W, mode_reg);

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    out_next   = out_reg;
    done_next  = 1'b0;
    capture    = 1'b0;
    mac_load   = 1'b0;
    mac_en     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          capture    = 1'b1;
          mac_load   = 1'b1;
          idx_next   = '0;
          state_next = ACC;
        end
      end
      ACC: begin
        mac_en = 1'b1;
        if (idx_reg == LAST_IDX) begin
          state_next = ACT;
        end else begin
          idx_next = idx_reg + 1'b1;
        end
      end
      ACT: begin
        out_next   = sat_val[OUT_W-1:0];
        done_next  = 1'b1;
        idx_next   = '0;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      out_reg   <= '0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      out_reg   <= out_next;
      done_reg  <= done_next;
    end
  end

  // Operands are snapshotted at start so later bus changes cannot leak in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inputs_reg  <= '0;
      weights_reg <= '0;
      mode_reg    <= ACT_RELU;
    end else if (capture) begin
      inputs_reg  <= inputs;
      weights_reg <= weights;
      mode_reg    <= act_mode;
    end
  end

  assign busy = (state_reg != IDLE);
  assign out  = out_reg;
  assign done = done_reg;

endmodule

// File: tb/tb_neuron_seq.sv
// Randomized self-checking bench for neuron_seq against an arithmetic
// reference model (sum of products, then clamp).
module tb_neuron_seq;

  localparam int N  = 9;
  localparam int DW = 8;
  localparam int WW = 8;
  localparam int AW = 24;
  localparam int OW = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            act_mode = 1'b0;
  logic [N*DW-1:0] inputs = '0;
  logic [N*WW-1:0] weights = '0;
`ifdef NEURON_BIAS_EN
  logic signed [AW-1:0] bias = '0;
`endif
  logic            busy;
  logic [OW-1:0]   out;
  logic            done;

  int total = 0;
  int bad   = 0;
  int in_a [N];
  int w_a  [N];
  int bias_v = 0;

  always #5 clk = ~clk;

  neuron_seq #(
    .N_INPUTS (N),
    .DATA_W   (DW),
    .WEIGHT_W (WW),
    .ACC_W    (AW),
    .OUT_W    (OW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .act_mode (act_mode),
    .inputs   (inputs),
    .weights  (weights),
`ifdef NEURON_BIAS_EN
    .bias     (bias),
`endif
    .busy     (busy),
    .out      (out),
    .done     (done)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic apply_ops();
    for (int i = 0; i < N; i++) begin
      inputs[i*DW +: DW]  = in_a[i][DW-1:0];
      weights[i*WW +: WW] = w_a[i][WW-1:0];
    end
`ifdef NEURON_BIAS_EN
    bias = AW'(bias_v);
`endif
  endtask

  task automatic fill(input int iv, input int wv);
    for (int i = 0; i < N; i++) begin
      in_a[i] = iv;
      w_a[i]  = wv;
    end
  endtask

  task automatic fill_rand();
    for (int i = 0; i < N; i++) begin
      in_a[i] = int'($urandom_range(0, 255));
      w_a[i]  = int'($urandom_range(0, 255)) - 128;
    end
  endtask

  // Reference: dot product plus bias, then clamp to the mode's range.
  function automatic logic [7:0] model(input logic mode);
    longint s;
    s = bias_v;
    for (int i = 0; i < N; i++) s += longint'(in_a[i]) * longint'(w_a[i]);
    if (mode == 1'b0) begin
      if (s < 0) s = 0;
      if (s > 255) s = 255;
    end else begin
      if (s < -128) s = -128;
      if (s > 127) s = 127;
    end
    return 8'(s);
  endfunction

  // One job: start pulse, optional disturbance at edge k+disturb_at,
  // check latency, busy window, result and single done pulse.
  task automatic run_job(input logic mode, input int disturb_at, input string tag);
    logic [7:0] exp;
    int j;
    int extra;
    bit busy_ok;
    exp = model(mode);
    @(negedge clk);
    apply_ops();
    act_mode = mode;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    busy_ok = 1'b1;
    for (j = 1; j <= 20; j++) begin
      if (disturb_at > 0 && j == disturb_at) begin
        fill_rand();
        apply_ops();
        act_mode = ~mode;
        start = 1'b1;
      end else if (disturb_at > 0 && j == disturb_at + 1) begin
        start = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      if (done) break;
      if (busy !== 1'b1) busy_ok = 1'b0;
    end
    start = 1'b0;
    chk({tag, "_busy_window"}, 64'(busy_ok), 64'd1);
    chk({tag, "_latency"}, 64'(j), 64'(N + 1));
    chk({tag, "_out"}, 64'(out), 64'(exp));
    chk({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    @(negedge clk);
    chk({tag, "_done_single"}, 64'(done), 64'd0);
    if (disturb_at > 0) begin
      extra = 0;
      for (int c = 0; c < 14; c++) begin
        @(negedge clk);
        if (done) extra++;
      end
      chk({tag, "_no_extra_done"}, 64'(extra), 64'd0);
      chk({tag, "_out_hold"}, 64'(out), 64'(exp));
    end
    $display("job %s mode=%0d out=0x%0h exp=0x%0h", tag, mode, out, exp);
  endtask

  initial begin
    int edges[$];
    int dcount;
    logic [7:0] exp;

    fill(0, 0);
    apply_ops();
    #12;
    chk("reset_out", 64'(out), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    fill(1, 1);     run_job(1'b0, 0, "ones_relu");
    fill(1, -1);    run_job(1'b0, 0, "neg_relu");
    fill(1, -1);    run_job(1'b1, 0, "neg_lin");
    fill(255, 127); run_job(1'b0, 0, "max_relu");
    fill(255, 127); run_job(1'b1, 0, "max_lin");
    fill(255, -128); run_job(1'b1, 0, "min_lin");

    fill(1, 1);     run_job(1'b0, 3, "disturb");

    // Start held high: one result every N+2 edges.
    fill_rand();
    exp = model(1'b1);
    @(negedge clk);
    apply_ops();
    act_mode = 1'b1;
    start = 1'b1;
    for (int e = 1; e <= 60; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        edges.push_back(e);
        chk("held_out", 64'(out), 64'(exp));
      end
    end
    start = 1'b0;
    chk("held_count_ge4", 64'(edges.size() >= 4), 64'd1);
    for (int i = 1; i < edges.size(); i++) begin
      chk("held_period", 64'(edges[i] - edges[i-1]), 64'(N + 2));
    end
    $display("held start: %0d results", edges.size());
    for (int c = 0; c < 30 && busy; c++) @(negedge clk);
    chk("held_idle", 64'(busy), 64'd0);

    // Reset abort mid-job.
    fill(255, 127);
    @(negedge clk);
    apply_ops();
    act_mode = 1'b0;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_out", 64'(out), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dcount = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (done) dcount++;
    end
    chk("abort_no_done", 64'(dcount), 64'd0);
    $display("reset abort: done pulses after abort=%0d", dcount);
    fill(2, 3);     run_job(1'b0, 0, "after_abort");

`ifdef NEURON_BIAS_EN
    fill(1, 1);
    bias_v = -10;   run_job(1'b0, 0, "bias_m10_relu");
    bias_v = -10;   run_job(1'b1, 0, "bias_m10_lin");
    bias_v = 100;   run_job(1'b0, 0, "bias_p100_relu");
    bias_v = 0;
`endif

    for (int t = 0; t < 25; t++) begin
      fill_rand();
`ifdef NEURON_BIAS_EN
      bias_v = int'($urandom_range(0, 4000)) - 2000;
`endif
      if (t % 5 == 0) fill(int'($urandom_range(0, 3)), int'($urandom_range(0, 6)) - 3);
      run_job(1'($urandom_range(0, 1)), 0, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
